tri_span_writer: RTL and testbench

- Downstream stage of the triangle scanline interpolator: consumes one span per scanline (y, x_start, x_end, colour) and emits one pixel write per cycle into the framebuffer/line-buffer write port.
- Buffers up to 2 spans so the interpolator can run ahead while the writer is stalled.
- Clips each span to the horizontal resolution.
- Reports busy, per-span completion and a running pixel count.

---
 rtl/tri_span_writer_pkg.sv | 21 ++
 rtl/tri_span_writer_if.sv | 38 +++
 rtl/tri_span_writer_span_fifo2.sv | 47 ++++
 rtl/tri_span_writer.sv | 112 +++++++++++
 tb/tb_tri_span_writer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_span_writer_pkg.sv
// Shared definitions for the triangle span writer: field widths, FSM states and
// the layout of a packed span word {y, x_start, x_end, colour}.
package tri_span_writer_pkg;

    localparam int unsigned X_W         = 8;
    localparam int unsigned Y_W         = 8;
    localparam int unsigned COLOR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Offsets measured from the top of the colour field, which sits at bit 0.
    localparam int unsigned XE_OFS     = 0;
    localparam int unsigned XS_OFS     = X_W;
    localparam int unsigned Y_OFS      = 2 * X_W;
    localparam int unsigned SPAN_HDR_W = Y_W + 2 * X_W;

endpackage

// File: rtl/tri_span_writer_if.sv
// Span input handshake, pixel write port and status outputs of the span writer.
interface tri_span_writer_if
    import tri_span_writer_pkg::*;
#(
    parameter int unsigned COLOR_W = COLOR_W_DEF
);
    logic               span_valid_i;
    logic               span_ready_o;
    logic [Y_W-1:0]     span_y_i;
    logic [X_W-1:0]     span_x_start_i;
    logic [X_W-1:0]     span_x_end_i;
    logic [COLOR_W-1:0] span_color_i;

    logic               pix_we_o;
    logic               pix_ready_i;
    logic [X_W-1:0]     pix_x_o;
    logic [Y_W-1:0]     pix_y_o;
    logic [COLOR_W-1:0] pix_color_o;

    logic               busy_o;
    logic               span_done_o;
    logic [15:0]        pix_count_o;

    modport master (
        output span_valid_i, span_y_i, span_x_start_i, span_x_end_i, span_color_i,
        output pix_ready_i,
        input  span_ready_o, pix_we_o, pix_x_o, pix_y_o, pix_color_o,
        input  busy_o, span_done_o, pix_count_o
    );

    modport slave (
        input  span_valid_i, span_y_i, span_x_start_i, span_x_end_i, span_color_i,
        input  pix_ready_i,
        output span_ready_o, pix_we_o, pix_x_o, pix_y_o, pix_color_o,
        output busy_o, span_done_o, pix_count_o
    );

endinterface

// File: rtl/tri_span_writer_span_fifo2.sv
// Two-entry FIFO of packed span words; pushes while full and pops while empty are ignored.
module span_fifo2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/tri_span_writer.sv
// Span writer: buffers up to two spans, clips them to HRES and emits one pixel
// write per cycle, with a per-span completion pulse and a running pixel count.
module tri_span_writer
    import tri_span_writer_pkg::*;
#(
    parameter int unsigned HRES    = 160,
    parameter int unsigned COLOR_W = COLOR_W_DEF
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    tri_span_writer_if.slave bus
);

    localparam int unsigned  SPAN_W = SPAN_HDR_W + COLOR_W;
    localparam logic [X_W:0] HRES_C = (X_W + 1)'(HRES);

    logic [SPAN_W-1:0]  head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [X_W-1:0]     head_xs;
    logic [X_W-1:0]     head_xe;
    logic [X_W:0]       head_end;

    state_t             state;
    logic [X_W:0]       cur_x;
    logic [X_W:0]       end_c;
    logic [Y_W-1:0]     y_r;
    logic [COLOR_W-1:0] color_r;
    logic               pix_we_r;
    logic               done_r;
    logic [15:0]        pix_cnt;

    assign push     = bus.span_valid_i && bus.span_ready_o;
    assign pop      = !empty && (state != FILL);
    assign head_xs  = head[COLOR_W + XS_OFS +: X_W];
    assign head_xe  = head[COLOR_W + XE_OFS +: X_W];
    assign head_end = ({1'b0, head_xe} > HRES_C) ? HRES_C : {1'b0, head_xe};

    span_fifo2 #(.W(SPAN_W)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .pop   (pop),
        .din   ({bus.span_y_i, bus.span_x_start_i, bus.span_x_end_i, bus.span_color_i}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // IDLE and DONE share the pop path so spans stream back-to-back through DONE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cur_x    <= '0;
            end_c    <= '0;
            y_r      <= '0;
            color_r  <= '0;
            pix_we_r <= 1'b0;
            done_r   <= 1'b0;
            pix_cnt  <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (!empty) begin
                        cur_x   <= {1'b0, head_xs};
                        end_c   <= head_end;
                        y_r     <= head[COLOR_W + Y_OFS +: Y_W];
                        color_r <= head[COLOR_W-1:0];
                        if ({1'b0, head_xs} < head_end) begin
                            state    <= FILL;
                            pix_we_r <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (bus.pix_ready_i) begin
                        pix_cnt <= pix_cnt + 16'd1;
                        if (cur_x + 1'b1 == end_c) begin
                            state    <= DONE;
                            pix_we_r <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    pix_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.span_ready_o = !full && !wb_rst_i;
    assign bus.pix_we_o     = pix_we_r;
    assign bus.pix_x_o      = cur_x[X_W-1:0];
    assign bus.pix_y_o      = y_r;
    assign bus.pix_color_o  = color_r;
    assign bus.busy_o       = !empty || (state != IDLE);
    assign bus.span_done_o  = done_r;
    assign bus.pix_count_o  = pix_cnt;

endmodule

// File: tb/tb_tri_span_writer.sv
// Bench for tri_span_writer: directed scenarios plus randomized spans, all checked
// against a queue model of expected pixel writes and span completions.
module tb_tri_span_writer;

    localparam int unsigned HRES = 160;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   stop_rand = 1'b0;

    tri_span_writer_if #(.COLOR_W(CW)) bus ();

    tri_span_writer #(.HRES(HRES), .COLOR_W(CW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: every accepted span expands into its list of surviving pixels.
    typedef struct {
        int x;
        int y;
        int c;
        int id;
    } pix_t;

    pix_t        pq[$];
    int          dq[$];
    int          next_id = 0;
    logic [15:0] mcnt = '0;

    function automatic void model_span(input int y, input int xs, input int xe, input int c);
        int   e;
        pix_t p;
        e = (xe < int'(HRES)) ? xe : int'(HRES);
        for (int x = xs; x < e; x++) begin
            p.x = x; p.y = y; p.c = c; p.id = next_id;
            pq.push_back(p);
        end
        dq.push_back(next_id);
        next_id++;
    endfunction

    always @(negedge clk) begin
        pix_t p;
        int   id;
        if (rst) begin
            pq.delete();
            dq.delete();
            mcnt = '0;
        end else begin
            chk("pix_count", int'(bus.pix_count_o), int'(mcnt));
            if (bus.span_done_o) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    id = dq.pop_front();
                    chk("done_before_pixels", int'(pq.size() > 0 && pq[0].id == id), 0);
                end
            end
            if (bus.pix_we_o && bus.pix_ready_i) begin
                if (pq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    p = pq.pop_front();
                    chk("pix_x", int'(bus.pix_x_o), p.x);
                    chk("pix_y", int'(bus.pix_y_o), p.y);
                    chk("pix_color", int'(bus.pix_color_o), p.c);
                    mcnt = mcnt + 16'd1;
                end
            end
            if (bus.span_valid_i && bus.span_ready_o)
                model_span(int'(bus.span_y_i), int'(bus.span_x_start_i),
                           int'(bus.span_x_end_i), int'(bus.span_color_i));
        end
    end

    task automatic send(input logic [7:0] y, input logic [7:0] xs, input logic [7:0] xe,
                        input logic [CW-1:0] c);
        bus.span_y_i       = y;
        bus.span_x_start_i = xs;
        bus.span_x_end_i   = xe;
        bus.span_color_i   = c;
        bus.span_valid_i   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.span_ready_o) begin
                @(posedge clk);
                #1;
                bus.span_valid_i = 1'b0;
                return;
            end
        end
        bus.span_valid_i = 1'b0;
        chk("accept_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.busy_o && !bus.pix_we_o && pq.size() == 0) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  rdy_seq;
        int          xexp [5];
        logic [11:0] we_pat;
        logic [11:0] done_pat;
        int          xs_r;
        int          xe_r;

        bus.span_valid_i   = 1'b0;
        bus.span_y_i       = '0;
        bus.span_x_start_i = '0;
        bus.span_x_end_i   = '0;
        bus.span_color_i   = '0;
        bus.pix_ready_i    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pix_we", int'(bus.pix_we_o), 0);
        chk("rst_ready", int'(bus.span_ready_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_count", int'(bus.pix_count_o), 0);
        chk("rst_done", int'(bus.span_done_o), 0);
        chk("rst_pix_x", int'(bus.pix_x_o), 0);
        chk("rst_pix_y", int'(bus.pix_y_o), 0);
        chk("rst_pix_color", int'(bus.pix_color_o), 0);
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(bus.span_ready_o), 1);

        // Basic span
        @(posedge clk); #1;
        send(8'd10, 8'd5, 8'd9, 8'h3C);
        @(negedge clk);
        chk("basic_no_write_yet", int'(bus.pix_we_o), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("basic_we", int'(bus.pix_we_o), 1);
            chk("basic_x", int'(bus.pix_x_o), 5 + i);
            chk("basic_y", int'(bus.pix_y_o), 10);
            chk("basic_color", int'(bus.pix_color_o), 'h3C);
        end
        @(negedge clk);
        chk("basic_done", int'(bus.span_done_o), 1);
        chk("basic_we_off", int'(bus.pix_we_o), 0);
        chk("basic_count", int'(bus.pix_count_o), 4);
        wait_idle();

        // Backpressure
        @(posedge clk); #1;
        bus.pix_ready_i = 1'b0;
        send(8'd3, 8'd0, 8'd3, 8'h55);
        @(posedge clk); #1;
        rdy_seq = 5'b11010;
        xexp = '{0, 0, 1, 1, 2};
        for (int i = 0; i < 5; i++) begin
            bus.pix_ready_i = rdy_seq[i];
            @(negedge clk);
            chk("bp_we", int'(bus.pix_we_o), 1);
            chk("bp_x", int'(bus.pix_x_o), xexp[i]);
            chk("bp_y", int'(bus.pix_y_o), 3);
            chk("bp_color", int'(bus.pix_color_o), 'h55);
            @(posedge clk); #1;
        end
        bus.pix_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_done", int'(bus.span_done_o), 1);
        chk("bp_count", int'(bus.pix_count_o), 7);
        wait_idle();

        // Empty and clipped spans
        @(posedge clk); #1;
        send(8'd20, 8'd20, 8'd20, 8'h01);
        @(negedge clk);
        chk("empty_done_early", int'(bus.span_done_o), 0);
        @(negedge clk);
        chk("empty_done", int'(bus.span_done_o), 1);
        chk("empty_we", int'(bus.pix_we_o), 0);
        wait_idle();
        @(posedge clk); #1;
        send(8'd21, 8'd170, 8'd200, 8'h02);
        @(negedge clk);
        chk("clip_all_done_early", int'(bus.span_done_o), 0);
        @(negedge clk);
        chk("clip_all_done", int'(bus.span_done_o), 1);
        chk("clip_all_we", int'(bus.pix_we_o), 0);
        wait_idle();
        @(posedge clk); #1;
        send(8'd22, 8'd155, 8'd200, 8'h03);
        wait_idle();
        chk("clip_part_count", int'(bus.pix_count_o), 12);

        // FIFO full, then drain with one DONE cycle between spans
        @(posedge clk); #1;
        bus.pix_ready_i = 1'b0;
        send(8'd40, 8'd10, 8'd12, 8'h11);
        send(8'd41, 8'd20, 8'd22, 8'h12);
        send(8'd42, 8'd30, 8'd32, 8'h13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready", int'(bus.span_ready_o), 0);
            chk("full_head_x", int'(bus.pix_x_o), 10);
        end
        fork
            send(8'd43, 8'd40, 8'd42, 8'h14);
            begin
                @(posedge clk); #1;
                bus.pix_ready_i = 1'b1;
                for (int i = 11; i >= 0; i--) begin
                    @(negedge clk);
                    we_pat[i]   = bus.pix_we_o;
                    done_pat[i] = bus.span_done_o;
                end
            end
        join
        chk("drain_we_pattern", int'(we_pat), 'b110110110110);
        chk("drain_done_pattern", int'(done_pat), 'b001001001001);
        wait_idle();
        chk("drain_count", int'(bus.pix_count_o), 20);

        // Reset mid-span
        @(posedge clk); #1;
        send(8'd50, 8'd0, 8'd100, 8'h07);
        repeat (10) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", int'(bus.pix_we_o), 0);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_count", int'(bus.pix_count_o), 0);
        chk("mid_rst_done", int'(bus.span_done_o), 0);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        send(8'd60, 8'd1, 8'd2, 8'h09);
        wait_idle();
        chk("post_rst_count", int'(bus.pix_count_o), 1);

        // Randomized spans with random write-port backpressure
        stop_rand = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        xs_r = int'($urandom_range(0, 255));
                        xe_r = int'($urandom_range(0, 255));
                    end else begin
                        xs_r = int'($urandom_range(0, 170));
                        xe_r = xs_r + int'($urandom_range(0, 12));
                        if (xe_r > 255) xe_r = 255;
                    end
                    send(8'($urandom_range(0, 255)), 8'(xs_r), 8'(xe_r), 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk); #1;
                    bus.pix_ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.pix_ready_i = 1'b1;
        wait_idle();
        chk("rand_model_drained", pq.size() + dq.size(), 0);

        // Counter wrap
        @(posedge clk); #1;
        force dut.pix_cnt = 16'hFFFE;
        mcnt = 16'hFFFE;
        #1;
        release dut.pix_cnt;
        @(negedge clk);
        chk("wrap_preload", int'(bus.pix_count_o), 'hFFFE);
        @(posedge clk); #1;
        send(8'd70, 8'd0, 8'd3, 8'hAA);
        wait_idle();
        chk("wrap_count", int'(bus.pix_count_o), 1);
        chk("final_busy", int'(bus.busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
